// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and defaults for the register-bank arbiter slice.
package reg_bank_arbiter_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 3;

    // Increment an index and wrap it back to zero at n
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = 32'd0;
        if (idx + 32'd1 >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_bank.sv
// DEPTH x DATA_W register bank: async active-low clear, synchronous
// single-port write, combinational read of the addressed word.
module reg_bank
    import reg_bank_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next-state of every word: only the addressed word changes on a write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[addr] = wdata;
        end else begin
            mem_d[addr] = mem_q[addr];
        end
    end

    // Storage flops, cleared to zero by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register bank between NUM_REQ
// requesters. Each transaction runs IDLE -> ACC -> DONE: the winner's
// request is captured in IDLE, the bank is accessed in ACC and the
// acknowledge with read data is presented for the single DONE cycle.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                hold_we_q, hold_we_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;

    logic                win_found_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                bank_we_s;
    logic [DATA_W-1:0]   bank_rdata_s;

    // Round-robin search: first pass from rr_ptr upward, second pass wraps to 0
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found_s && req[i] && (i >= int'(rr_ptr_q))) begin
                win_found_s = 1'b1;
                win_idx_s   = PTR_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found_s && req[i]) begin
                win_found_s = 1'b1;
                win_idx_s   = PTR_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign sel_we_s    = we[win_idx_s];
    assign sel_addr_s  = addr[int'(win_idx_s) * ADDR_W +: ADDR_W];
    assign sel_wdata_s = wdata[int'(win_idx_s) * DATA_W +: DATA_W];

    // The bank only ever sees the captured request, never live inputs
    assign bank_we_s = (state_q == ST_ACC) && hold_we_q;

    reg_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we_s),
        .addr  (hold_addr_q),
        .wdata (hold_wdata_q),
        .rdata (bank_rdata_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE waits for any request, ACC and DONE last one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values for each state
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        ack_d        = ack_q;
        busy_d       = busy_q;
        rdata_d      = rdata_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        case (state_q)
            ST_IDLE: begin
                ack_d = '0;
                if (win_found_s) begin
                    gnt_d        = NUM_REQ'(1) << win_idx_s;
                    busy_d       = 1'b1;
                    rr_ptr_d     = PTR_W'(wrap_inc(32'(win_idx_s), 32'(NUM_REQ)));
                    hold_we_d    = sel_we_s;
                    hold_addr_d  = sel_addr_s;
                    hold_wdata_d = sel_wdata_s;
                end else begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            ST_ACC: begin
                ack_d  = gnt_q;
                busy_d = 1'b1;
                if (hold_we_q) begin
                    rdata_d = hold_wdata_q;
                end else begin
                    rdata_d = bank_rdata_s;
                end
            end
            ST_DONE: begin
                ack_d  = '0;
                gnt_d  = '0;
                busy_d = 1'b0;
            end
            default: begin
                ack_d  = '0;
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            rdata_q      <= '0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            rdata_q      <= rdata_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (4 requesters, 16-bit, depth 8).
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [15:0] rdata;
    logic        busy;

    int n_total;
    int n_pass;

    logic [15:0] exp_rd [4];

    reg_bank_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (16),
        .ADDR_W  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .rdata (rdata),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        we    = 4'b0000;
        addr  = 12'h000;
        wdata = 64'h0;
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h1111;
        exp_rd[2] = 16'h0000;
        exp_rd[3] = 16'hBEEF;

        // Reset state
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        rst_n = 1'b1;

        // Requester 0 writes BEEF to addr 3
        req = 4'b0001; we = 4'b0001;
        addr[0 +: 3] = 3'd3; wdata[0 +: 16] = 16'hBEEF;
        tick();
        chk("w0_gnt", 32'(gnt), 32'h1);
        chk("w0_busy", 32'(busy), 32'h1);
        chk("w0_ack_early", 32'(ack), 32'h0);
        tick();
        chk("w0_ack", 32'(ack), 32'h1);
        chk("w0_rdata", 32'(rdata), 32'hBEEF);
        req = 4'b0000; we = 4'b0000;
        tick();
        chk("w0_done_ack", 32'(ack), 32'h0);
        chk("w0_done_gnt", 32'(gnt), 32'h0);
        chk("w0_done_busy", 32'(busy), 32'h0);
        chk("w0_rdata_hold", 32'(rdata), 32'hBEEF);

        // Requester 2 reads addr 3 back
        req = 4'b0100; addr[6 +: 3] = 3'd3;
        tick();
        chk("r2_gnt", 32'(gnt), 32'h4);
        tick();
        chk("r2_ack", 32'(ack), 32'h4);
        chk("r2_rdata", 32'(rdata), 32'hBEEF);
        req = 4'b0000;
        tick();

        // Requester 3 writes 1111 to addr 1 (pointer wraps to 0)
        req = 4'b1000; we = 4'b1000;
        addr[9 +: 3] = 3'd1; wdata[48 +: 16] = 16'h1111;
        tick();
        chk("w3_gnt", 32'(gnt), 32'h8);
        tick();
        chk("w3_ack", 32'(ack), 32'h8);
        chk("w3_rdata", 32'(rdata), 32'h1111);
        req = 4'b0000; we = 4'b0000;
        tick();

        // Full contention: each requester reads its own index address
        req = 4'b1111; we = 4'b0000;
        addr = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("cont%0d_gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            chk($sformatf("cont%0d_ack_acc", k), 32'(ack), 32'h0);
            tick();
            chk($sformatf("cont%0d_ack", k), 32'(ack), 32'(4'b0001 << (k % 4)));
            chk($sformatf("cont%0d_rdata", k), 32'(rdata), 32'(exp_rd[k % 4]));
            if (k == 4) begin
                req = 4'b0000;
            end else begin
                req = 4'b1111;
            end
            tick();
            chk($sformatf("cont%0d_ack_gap", k), 32'(ack), 32'h0);
            chk($sformatf("cont%0d_busy_gap", k), 32'(busy), 32'h0);
        end

        // Pointer fairness: serve 1, then 0 and 1 together -> 0 first
        req = 4'b0010;
        tick();
        chk("fair1_gnt", 32'(gnt), 32'h2);
        tick();
        chk("fair1_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();
        req = 4'b0011;
        tick();
        chk("fair_a_gnt", 32'(gnt), 32'h1);
        tick();
        chk("fair_a_ack", 32'(ack), 32'h1);
        req = 4'b0010;
        tick();
        tick();
        chk("fair_b_gnt", 32'(gnt), 32'h2);
        tick();
        chk("fair_b_ack", 32'(ack), 32'h2);
        chk("fair_b_rdata", 32'(rdata), 32'h1111);
        req = 4'b0000;
        tick();

        // Async reset during ACC of a write of 1234 to addr 5
        req = 4'b0001; we = 4'b0001;
        addr[0 +: 3] = 3'd5; wdata[0 +: 16] = 16'h1234;
        tick();
        chk("arst_gnt_before", 32'(gnt), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_ack", 32'(ack), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        req = 4'b0000; we = 4'b0000;
        tick();
        rst_n = 1'b1;
        req = 4'b0010; addr[3 +: 3] = 3'd5;
        tick();
        chk("arst_rd_gnt", 32'(gnt), 32'h2);
        tick();
        chk("arst_rd_ack", 32'(ack), 32'h2);
        chk("arst_rd_bank5", 32'(rdata), 32'h0);
        req = 4'b0000;
        tick();

        // Input change during ACC: captured values win
        req = 4'b0100; we = 4'b0100;
        addr[6 +: 3] = 3'd6; wdata[32 +: 16] = 16'hA5A5;
        tick();
        addr[6 +: 3] = 3'd7; wdata[32 +: 16] = 16'hFFFF;
        tick();
        chk("chg_ack", 32'(ack), 32'h4);
        chk("chg_rdata", 32'(rdata), 32'hA5A5);
        req = 4'b0000; we = 4'b0000;
        tick();
        req = 4'b0100; addr[6 +: 3] = 3'd6;
        tick();
        tick();
        chk("chg_rd6", 32'(rdata), 32'hA5A5);
        req = 4'b0000;
        tick();
        req = 4'b0100; addr[6 +: 3] = 3'd7;
        tick();
        tick();
        chk("chg_rd7", 32'(rdata), 32'h0);
        req = 4'b0000;
        tick();

        // Held req: requester 2 writes addr 4, then keeps req for a read of addr 6
        req = 4'b0100; we = 4'b0100;
        addr[6 +: 3] = 3'd4; wdata[32 +: 16] = 16'h4444;
        tick();
        tick();
        chk("held1_ack", 32'(ack), 32'h4);
        chk("held1_rdata", 32'(rdata), 32'h4444);
        we = 4'b0000; addr[6 +: 3] = 3'd6;
        tick();
        chk("held_idle_gnt", 32'(gnt), 32'h0);
        tick();
        chk("held2_gnt", 32'(gnt), 32'h4);
        tick();
        chk("held2_ack", 32'(ack), 32'h4);
        chk("held2_rdata", 32'(rdata), 32'hA5A5);
        addr[6 +: 3] = 3'd4;
        tick();
        tick();
        tick();
        chk("raw_rd4", 32'(rdata), 32'h4444);
        req = 4'b0000;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
